// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared defaults and A-register operation encoding for exec_unit
package exec_pkg;

    localparam int W_DEFAULT        = 8;
    localparam int CNT_INIT_DEFAULT = 8;

    // Operation applied to A/CF in one cycle; only the highest-priority strobe is honoured.
    typedef enum logic [2:0] {
        AOP_NONE = 3'd0,
        AOP_CLR  = 3'd1,
        AOP_LOAD = 3'd2,
        AOP_ADD  = 3'd3,
        AOP_SUB  = 3'd4,
        AOP_SHR  = 3'd5
    } a_op_e;

    // Fixed priority t6 > t4 > t1 > t9 > t5.
    function automatic a_op_e a_op_select(input logic t6, input logic t4, input logic t1,
                                          input logic t9, input logic t5);
        a_op_e op;
        op = AOP_NONE;
        if (t6) begin
            op = AOP_CLR;
        end else if (t4) begin
            op = AOP_LOAD;
        end else if (t1) begin
            op = AOP_ADD;
        end else if (t9) begin
            op = AOP_SUB;
        end else if (t5) begin
            op = AOP_SHR;
        end
        return op;
    endfunction

endpackage

// File: rtl/exec_unit_if.sv
// rtl/exec_unit_if.sv - strobe, data and result-handshake bundle between automaton and exec_unit
interface exec_unit_if import exec_pkg::*; #(
    parameter int W = W_DEFAULT
) ();

    logic         t1;
    logic         t2;
    logic         t3;
    logic         t4;
    logic         t5;
    logic         t6;
    logic         t7;
    logic         t8;
    logic         t9;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         x;
    logic         y;
    logic         ovf;

    // Control automaton plus result consumer.
    modport master (
        output t1, t2, t3, t4, t5, t6, t7, t8, t9, din, dout_ready,
        input  dout, dout_valid, x, y, ovf
    );

    // Execution unit.
    modport slave (
        input  t1, t2, t3, t4, t5, t6, t7, t8, t9, din, dout_ready,
        output dout, dout_valid, x, y, ovf
    );

endinterface

// File: rtl/exec_unit_out_holder.sv
// rtl/exec_unit_out_holder.sv - result register with valid/ready handshake and sticky overrun flag
module out_holder import exec_pkg::*; #(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         ovf
);

    logic [W-1:0] dout_q;
    logic [W-1:0] dout_d;
    logic         valid_q;
    logic         valid_d;
    logic         ovf_q;
    logic         ovf_d;
    logic         xfer;

    assign xfer = valid_q && out_ready;

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (load) begin
            dout_d  = load_data;
            valid_d = 1'b1;
            // Overrun only when an unconsumed result is replaced.
            if (valid_q && !out_ready) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign ovf        = ovf_q;

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - micro-op datapath: A/B registers, carry flag, down-counter C and result output
module exec_unit import exec_pkg::*; #(
    parameter int W        = W_DEFAULT,
    parameter int CNT_INIT = CNT_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       res,
    exec_unit_if.slave bus
);

    localparam int CW = (CNT_INIT < 2) ? 1 : $clog2(CNT_INIT + 1);

    logic [W-1:0]  a_q;
    logic [W-1:0]  a_d;
    logic [W-1:0]  b_q;
    logic [W-1:0]  b_d;
    logic [CW-1:0] c_q;
    logic [CW-1:0] c_d;
    logic          cf_q;
    logic          cf_d;
    logic [W:0]    sum;
    logic [W:0]    diff;
    a_op_e         a_op;
    logic [W-1:0]  oh_dout;
    logic          oh_valid;
    logic          oh_ovf;

    assign a_op = a_op_select(bus.t6, bus.t4, bus.t1, bus.t9, bus.t5);
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    // Bit W of the extended difference is the unsigned borrow.
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        a_d  = a_q;
        cf_d = cf_q;
        case (a_op)
            AOP_CLR: begin
                a_d  = '0;
                cf_d = 1'b0;
            end
            AOP_LOAD: a_d = bus.din;
            AOP_ADD: begin
                a_d  = sum[W-1:0];
                cf_d = sum[W];
            end
            AOP_SUB: begin
                a_d  = diff[W-1:0];
                cf_d = diff[W];
            end
            AOP_SHR: begin
                a_d  = {1'b0, a_q[W-1:1]};
                cf_d = a_q[0];
            end
            default: begin
                a_d  = a_q;
                cf_d = cf_q;
            end
        endcase
    end

    always_comb begin
        b_d = b_q;
        if (bus.t3) begin
            b_d = bus.din;
        end
    end

    // Counter saturates at zero; reload beats decrement.
    always_comb begin
        c_d = c_q;
        if (bus.t7) begin
            c_d = CW'(CNT_INIT);
        end else if (bus.t2 && (c_q != '0)) begin
            c_d = c_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            cf_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            c_q  <= c_d;
            cf_q <= cf_d;
        end
    end

    out_holder #(.W(W)) u_out_holder (
        .clk        (clk),
        .res        (res),
        .load       (bus.t8),
        .load_data  (a_q),
        .out_ready  (bus.dout_ready),
        .dout       (oh_dout),
        .dout_valid (oh_valid),
        .ovf        (oh_ovf)
    );

    // Flags decode registers only, keeping the automaton loop-free.
    assign bus.x          = (c_q == '0);
    assign bus.y          = cf_q;
    assign bus.dout       = oh_dout;
    assign bus.dout_valid = oh_valid;
    assign bus.ovf        = oh_ovf;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - scoreboard bench for exec_unit micro-ops and result handshake
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    exec_unit_if #(.W(8)) bus ();

    exec_unit #(.W(8), .CNT_INIT(8)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.t1 = 0; bus.t2 = 0; bus.t3 = 0; bus.t4 = 0; bus.t5 = 0;
        bus.t6 = 0; bus.t7 = 0; bus.t8 = 0; bus.t9 = 0;
        bus.din = 8'h00; bus.dout_ready = 1'b0;
    endtask

    task automatic load_a(input logic [7:0] v);
        bus.din = v; bus.t4 = 1; tick(); bus.t4 = 0;
    endtask

    // Capture A into dout with the consumer stalled; the expected value joins the scoreboard.
    task automatic emit(input logic [7:0] e);
        exp_q.push_back(e);
        bus.dout_ready = 0; bus.t8 = 1; tick(); bus.t8 = 0;
    endtask

    task automatic release_out();
        bus.dout_ready = 1; tick(); bus.dout_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        res = 1; bus.t1 = 1; bus.t7 = 1; bus.t8 = 1; tick(); idle_inputs(); res = 0;
        repeat (5) tick();
        n_cmp++; if (bus.x !== 1'b1) begin n_err++; $display("FAIL reset_x got=%b exp=1", bus.x); end
        n_cmp++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL reset_y got=%b exp=0", bus.y); end
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        n_cmp++; if (bus.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        // A+B with both cleared must leave A at zero and no carry.
        bus.t1 = 1; tick(); bus.t1 = 0;
        emit(8'h00);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL reset_ab got=%h exp=%h", bus.dout, exp_v); end
        n_cmp++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL reset_ab_cf got=%b exp=0", bus.y); end
        release_out();
    endtask

    task automatic test_arith();
        logic [7:0] exp_a[4];
        logic       exp_y[4];
        exp_a[0] = 8'h0A; exp_y[0] = 0;
        exp_a[1] = 8'h05; exp_y[1] = 0;
        exp_a[2] = 8'h00; exp_y[2] = 0;
        exp_a[3] = 8'hFB; exp_y[3] = 1;
        bus.din = 8'h05; bus.t3 = 1; bus.t4 = 1; tick(); bus.t3 = 0; bus.t4 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) bus.t1 = 1; else bus.t9 = 1;
            tick(); bus.t1 = 0; bus.t9 = 0;
            n_cmp++; if (bus.y !== exp_y[i]) begin n_err++; $display("FAIL arith_y[%0d] got=%b exp=%b", i, bus.y, exp_y[i]); end
            emit(exp_a[i]);
            n_cmp++; if (bus.dout_valid !== 1'b1) begin n_err++; $display("FAIL arith_valid[%0d] got=%b exp=1", i, bus.dout_valid); end
            exp_v = exp_q.pop_front();
            n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL arith_a[%0d] got=%h exp=%h", i, bus.dout, exp_v); end
            release_out();
        end
        // Carry out of an addition: 0xFB + 0x05.
        bus.t1 = 1; tick(); bus.t1 = 0;
        n_cmp++; if (bus.y !== 1'b1) begin n_err++; $display("FAIL arith_carry got=%b exp=1", bus.y); end
        emit(8'h00);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL arith_carry_a got=%h exp=%h", bus.dout, exp_v); end
        release_out();
    endtask

    task automatic test_counter();
        bus.t7 = 1; tick(); bus.t7 = 0;
        n_cmp++; if (bus.x !== 1'b0) begin n_err++; $display("FAIL cnt_load got=%b exp=0", bus.x); end
        for (int i = 1; i <= 9; i++) begin
            bus.t2 = 1; tick(); bus.t2 = 0;
            n_cmp++; if (bus.x !== (i >= 8)) begin n_err++; $display("FAIL cnt_dec[%0d] got=%b exp=%b", i, bus.x, (i >= 8)); end
        end
        bus.t7 = 1; bus.t2 = 1; tick(); bus.t7 = 0; bus.t2 = 0;
        n_cmp++; if (bus.x !== 1'b0) begin n_err++; $display("FAIL cnt_t7_wins got=%b exp=0", bus.x); end
        for (int i = 1; i <= 8; i++) begin
            bus.t2 = 1; tick(); bus.t2 = 0;
            n_cmp++; if (bus.x !== (i == 8)) begin n_err++; $display("FAIL cnt_reload[%0d] got=%b exp=%b", i, bus.x, (i == 8)); end
        end
    endtask

    task automatic test_shift_priority();
        // CF is 1 here from the previous carry, so clearing it is observable.
        load_a(8'h80);
        bus.t5 = 1; bus.t6 = 1; tick(); bus.t5 = 0; bus.t6 = 0;
        n_cmp++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL clr_over_shr_cf got=%b exp=0", bus.y); end
        emit(8'h00);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL clr_over_shr_a got=%h exp=%h", bus.dout, exp_v); end
        release_out();
        load_a(8'h81);
        bus.t5 = 1; tick(); bus.t5 = 0;
        n_cmp++; if (bus.y !== 1'b1) begin n_err++; $display("FAIL shr_cf got=%b exp=1", bus.y); end
        emit(8'h40);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL shr_a got=%h exp=%h", bus.dout, exp_v); end
        release_out();
        // B is 0x05 throughout.
        bus.din = 8'h33; bus.t4 = 1; bus.t1 = 1; tick(); bus.t4 = 0; bus.t1 = 0;
        emit(8'h33);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL load_over_add got=%h exp=%h", bus.dout, exp_v); end
        release_out();
        bus.t1 = 1; bus.t9 = 1; tick(); bus.t1 = 0; bus.t9 = 0;
        emit(8'h38);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL add_over_sub got=%h exp=%h", bus.dout, exp_v); end
        release_out();
        bus.t9 = 1; bus.t5 = 1; tick(); bus.t9 = 0; bus.t5 = 0;
        emit(8'h33);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL sub_over_shr got=%h exp=%h", bus.dout, exp_v); end
        release_out();
    endtask

    task automatic test_overrun();
        load_a(8'h11);
        emit(8'h11);
        n_cmp++; if (bus.dout !== exp_q[0]) begin n_err++; $display("FAIL ovr_first got=%h exp=%h", bus.dout, exp_q[0]); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovr_first_ovf got=%b exp=0", bus.ovf); end
        load_a(8'h22);
        // The unconsumed 0x11 is overwritten and never delivered.
        void'(exp_q.pop_front());
        emit(8'h22);
        n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", bus.ovf); end
        n_cmp++; if (bus.dout_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got=%b exp=1", bus.dout_valid); end
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL ovr_dout got=%h exp=%h", bus.dout, exp_v); end
        release_out();
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain got=%b exp=0", bus.dout_valid); end
        n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", bus.ovf); end
        repeat (2) tick();
        n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovr_hold got=%b exp=1", bus.ovf); end
    endtask

    task automatic test_back_to_back();
        res = 1; tick(); res = 0;
        exp_q.delete();
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf_clr got=%b exp=0", bus.ovf); end
        load_a(8'h5A);
        emit(8'h5A);
        load_a(8'hA5);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", bus.dout, exp_v); end
        exp_q.push_back(8'hA5);
        bus.t8 = 1; bus.dout_ready = 1; tick(); bus.t8 = 0; bus.dout_ready = 0;
        n_cmp++; if (bus.dout_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%b exp=1", bus.dout_valid); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL b2b_no_ovf got=%b exp=0", bus.ovf); end
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", bus.dout, exp_v); end
        // t8 alongside t4 captures A from before the load.
        exp_q.push_back(8'hA5);
        bus.din = 8'h3C; bus.t4 = 1; bus.t8 = 1; bus.dout_ready = 1; tick();
        bus.t4 = 0; bus.t8 = 0; bus.dout_ready = 0;
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.dout !== exp_v) begin n_err++; $display("FAIL b2b_pre_update got=%h exp=%h", bus.dout, exp_v); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL b2b_pre_ovf got=%b exp=0", bus.ovf); end
        bus.t1 = 1; tick(); bus.t1 = 0;
        res = 1; bus.t8 = 1; bus.t7 = 1; tick(); res = 0; idle_inputs();
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", bus.dout_valid); end
        n_cmp++; if (bus.dout !== 8'h00) begin n_err++; $display("FAIL rst_dout got=%h exp=00", bus.dout); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf); end
        n_cmp++; if (bus.x !== 1'b1) begin n_err++; $display("FAIL rst_x got=%b exp=1", bus.x); end
        n_cmp++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL rst_y got=%b exp=0", bus.y); end
        tick();
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold got=%b exp=0", bus.dout_valid); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_arith();
        test_counter();
        test_shift_priority();
        test_overrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
